exu_fpu_sched: RTL and testbench

Issue/retire scheduler that sits between the FP decode stage and the fpnew-based FPU execution wrapper. It tracks every in-flight FP op in an in-order tag queue and holds a 32-entry destination scoreboard, so RAW and WAW hazards on f-registers stall decode. It routes FPU results to the FP register-file write port, accumulates sticky fflags for FCSR, and sequences flush so that no killed op ever writes back.

---
 rtl/exu_fpu_pkg.sv | 19 +
 rtl/exu_fpu_sched_if.sv | 25 ++
 rtl/exu_fpu_tagq.sv | 49 ++++
 rtl/exu_fpu_sched.sv | 118 +++++++++++
 tb/tb_exu_fpu_sched.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_fpu_pkg.sv
// Shared types for the FP issue/retire scheduler: accrued-flag layout and
// scheduler FSM states.
package exu_fpu_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } sched_state_e;

endpackage

// File: rtl/exu_fpu_sched_if.sv
// Scheduler <-> FPU wrapper link: op launch, result return and kill.
interface exu_fpu_sched_if;

  // An op transfers when fpu_in_valid & fpu_in_ready are both high on a
  // rising edge; a result transfers on fpu_out_valid & fpu_out_ready.
  // Neither valid may wait for its ready; fpu_flush kills everything in flight.
  logic        fpu_in_valid;
  logic        fpu_in_ready;
  logic        fpu_out_valid;
  logic        fpu_out_ready;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_status;
  logic        fpu_flush;

  modport master (
    output fpu_in_valid, fpu_out_ready, fpu_flush,
    input  fpu_in_ready, fpu_out_valid, fpu_result, fpu_status
  );

  modport slave (
    input  fpu_in_valid, fpu_out_ready, fpu_flush,
    output fpu_in_ready, fpu_out_valid, fpu_result, fpu_status
  );

endinterface

// File: rtl/exu_fpu_tagq.sv
// In-order tag queue holding the destination register of each in-flight FP op.
module exu_fpu_tagq #(
  parameter int DEPTH = 4,
  parameter int RW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [RW-1:0]            push_rd,
  input  logic                     pop,
  input  logic                     clear,
  output logic [RW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_rd;
  end

  assign head  = mem[rp];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/exu_fpu_sched.sv
// FP issue/retire scheduler: hazard-checked launch into the FPU, in-order
// writeback routing, sticky fflags accrual and one-cycle flush sequencing.
module exu_fpu_sched
  import exu_fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_fp_valid,
  input  logic [RW-1:0]         dec_rd,
  input  logic [RW-1:0]         dec_rs1,
  input  logic [RW-1:0]         dec_rs2,
  input  logic [RW-1:0]         dec_rs3,
  input  logic [2:0]            dec_rs_en,
  output logic                  dec_stall,
  exu_fpu_sched_if.master       fpu,
  input  logic                  flush_lower,
  output logic                  wb_valid,
  output logic [RW-1:0]         wb_rd,
  output logic [31:0]           wb_data,
  output logic [4:0]            fflags,
  input  logic                  csr_fflags_we,
  input  logic [4:0]            csr_fflags_wd,
  output logic                  sched_busy,
  output sched_state_e          sched_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [(2**RW)-1:0] sb;
  fflags_t            flags_q;
  logic               hazard;
  logic               can_launch;
  logic               issue;
  logic               retire;
  logic               in_flush;
  logic [RW-1:0]      head;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;

  assign in_flush   = (sched_state == FLUSH);
  assign hazard     = (dec_rs_en[0] & sb[dec_rs1]) | (dec_rs_en[1] & sb[dec_rs2]) |
                      (dec_rs_en[2] & sb[dec_rs3]) | sb[dec_rd];
  assign can_launch = dec_fp_valid & ~hazard & ~full & ~in_flush & ~flush_lower;
  assign issue      = can_launch & fpu.fpu_in_ready;
  assign dec_stall  = dec_fp_valid & ~issue;
  assign fpu.fpu_in_valid = can_launch;

  // A result arriving with an empty queue is ignored so it cannot corrupt the head.
  assign retire   = fpu.fpu_out_valid & ~in_flush & ~flush_lower & ~empty;
  assign wb_valid = retire;
  assign wb_rd    = retire ? head : '0;
  assign wb_data  = retire ? fpu.fpu_result : '0;

  assign fflags     = flags_q;
  assign sched_busy = ~empty;

  exu_fpu_tagq #(.DEPTH(DEPTH), .RW(RW)) u_tagq (
    .clk     (clk),
    .rst     (rst),
    .push    (issue),
    .push_rd (dec_rd),
    .pop     (retire),
    .clear   (in_flush),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sched_state       <= IDLE;
      fpu.fpu_flush     <= 1'b0;
      fpu.fpu_out_ready <= 1'b1;
    end else begin
      fpu.fpu_flush     <= flush_lower;
      fpu.fpu_out_ready <= ~flush_lower;
      if (flush_lower) begin
        sched_state <= FLUSH;
      end else begin
        case (sched_state)
          IDLE:    if (issue) sched_state <= BUSY;
          BUSY:    if (retire && !issue && count == CW'(1)) sched_state <= IDLE;
          FLUSH:   sched_state <= IDLE;
          default: sched_state <= IDLE;
        endcase
      end
    end
  end

  // Set after clear so a just-freed register re-issued in the same cycle stays busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb      <= '0;
      flags_q <= '0;
    end else begin
      if (in_flush) begin
        sb <= '0;
      end else begin
        if (retire) sb[head]   <= 1'b0;
        if (issue)  sb[dec_rd] <= 1'b1;
      end
      if (csr_fflags_we)
        flags_q <= fflags_t'(csr_fflags_wd);
      else if (retire)
        flags_q <= fflags_t'(flags_q | fpu.fpu_status);
    end
  end

  a_no_orphan_result: assert property (@(posedge clk) disable iff (rst)
    !(fpu.fpu_out_valid && empty && !in_flush))
    else $error("fpu_out_valid with no op in flight");

endmodule

// File: tb/tb_exu_fpu_sched.sv
// Bench for exu_fpu_sched: directed scenarios plus a randomized run against
// a queue-based reference model.
module tb_exu_fpu_sched;
  import exu_fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int RW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_fp_valid;
  logic [RW-1:0] dec_rd, dec_rs1, dec_rs2, dec_rs3;
  logic [2:0]    dec_rs_en;
  logic          dec_stall;
  logic          flush_lower;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [31:0]   wb_data;
  logic [4:0]    fflags;
  logic          csr_fflags_we;
  logic [4:0]    csr_fflags_wd;
  logic          sched_busy;
  sched_state_e  sched_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: destinations of in-flight ops, flush-cycle flag, flags.
  logic [RW-1:0] exp_q[$];
  bit            m_flush;
  logic [4:0]    m_flags;

  exu_fpu_sched_if fif();

  exu_fpu_sched #(.DEPTH(DEPTH), .RW(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_fp_valid  (dec_fp_valid),
    .dec_rd        (dec_rd),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_rs3       (dec_rs3),
    .dec_rs_en     (dec_rs_en),
    .dec_stall     (dec_stall),
    .fpu           (fif),
    .flush_lower   (flush_lower),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fflags        (fflags),
    .csr_fflags_we (csr_fflags_we),
    .csr_fflags_wd (csr_fflags_wd),
    .sched_busy    (sched_busy),
    .sched_state   (sched_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec_fp_valid      = 1'b0;
    dec_rd            = '0;
    dec_rs1           = '0;
    dec_rs2           = '0;
    dec_rs3           = '0;
    dec_rs_en         = '0;
    flush_lower       = 1'b0;
    csr_fflags_we     = 1'b0;
    csr_fflags_wd     = '0;
    fif.fpu_in_ready  = 1'b0;
    fif.fpu_out_valid = 1'b0;
    fif.fpu_result    = '0;
    fif.fpu_status    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    go();
    rst = 1'b0;
    exp_q.delete();
    m_flush = 1'b0;
    m_flags = '0;
    fif.fpu_in_ready = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic op(input int rd, input int rs1, input int rs2, input int rs3,
                    input logic [2:0] en);
    dec_fp_valid = 1'b1;
    dec_rd       = rd[RW-1:0];
    dec_rs1      = rs1[RW-1:0];
    dec_rs2      = rs2[RW-1:0];
    dec_rs3      = rs3[RW-1:0];
    dec_rs_en    = en;
  endtask

  function automatic bit in_flight(logic [RW-1:0] r);
    foreach (exp_q[i]) if (exp_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", dec_stall); end
    checks++; if (fif.fpu_in_valid !== 1'b0) begin failures++; $display("FAIL rst_in_valid got=%0b exp=0", fif.fpu_in_valid); end
    checks++; if (fif.fpu_out_ready !== 1'b1) begin failures++; $display("FAIL rst_out_ready got=%0b exp=1", fif.fpu_out_ready); end
    checks++; if (fif.fpu_flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0b exp=0", fif.fpu_flush); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%0b exp=0", wb_valid); end
    checks++; if (wb_rd !== '0) begin failures++; $display("FAIL rst_wb_rd got=%0d exp=0", wb_rd); end
    checks++; if (wb_data !== '0) begin failures++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
    checks++; if (fflags !== 5'b0) begin failures++; $display("FAIL rst_fflags got=%b exp=0", fflags); end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", sched_busy); end
    checks++; if (sched_state !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", sched_state, IDLE); end
    rst = 1'b0;
    go();
  endtask

  task automatic test_back_to_back();
    do_reset();
    op(1, 10, 11, 0, 3'b011); #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall_f1 got=%0b exp=0", dec_stall); end
    checks++; if (fif.fpu_in_valid !== 1'b1) begin failures++; $display("FAIL b2b_launch_f1 got=%0b exp=1", fif.fpu_in_valid); end
    go();
    op(2, 12, 13, 0, 3'b011); #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall_f2 got=%0b exp=0", dec_stall); end
    checks++; if (sched_state !== BUSY) begin failures++; $display("FAIL b2b_state_busy got=%0d exp=%0d", sched_state, BUSY); end
    go();
    dec_fp_valid = 1'b0; fif.fpu_out_valid = 1'b1; fif.fpu_result = 32'h3f80_0000; #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL b2b_wb1_valid got=%0b exp=1", wb_valid); end
    checks++; if (wb_rd !== 5'd1) begin failures++; $display("FAIL b2b_wb1_rd got=%0d exp=1", wb_rd); end
    checks++; if (wb_data !== 32'h3f80_0000) begin failures++; $display("FAIL b2b_wb1_data got=%h exp=3f800000", wb_data); end
    go();
    fif.fpu_result = 32'h4000_0000; #1;
    checks++; if (wb_rd !== 5'd2) begin failures++; $display("FAIL b2b_wb2_rd got=%0d exp=2", wb_rd); end
    checks++; if (wb_data !== 32'h4000_0000) begin failures++; $display("FAIL b2b_wb2_data got=%h exp=40000000", wb_data); end
    go();
    fif.fpu_out_valid = 1'b0; op(2, 1, 2, 0, 3'b011); #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL b2b_sb_cleared got=%0b exp=0", dec_stall); end
    checks++; if (sched_state !== IDLE) begin failures++; $display("FAIL b2b_state_idle got=%0d exp=%0d", sched_state, IDLE); end
    go();
  endtask

  task automatic test_raw();
    do_reset();
    op(3, 0, 0, 0, 3'b000); #1;
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL raw_issue_f3 got=%0b exp=0", dec_stall); end
    go();
    op(4, 3, 5, 6, 3'b001); #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL raw_stall_c1 got=%0b exp=1", dec_stall); end
    checks++; if (fif.fpu_in_valid !== 1'b0) begin failures++; $display("FAIL raw_no_launch got=%0b exp=0", fif.fpu_in_valid); end
    go(); #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL raw_stall_c2 got=%0b exp=1", dec_stall); end
    go();
    fif.fpu_out_valid = 1'b1; fif.fpu_result = 32'h4040_0000; #1;
    checks++; if (wb_rd !== 5'd3 || wb_valid !== 1'b1) begin failures++; $display("FAIL raw_wb_f3 got=%0b/%0d exp=1/3", wb_valid, wb_rd); end
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL raw_stall_wb got=%0b exp=1", dec_stall); end
    go();
    fif.fpu_out_valid = 1'b0; #1;
    checks++; if (dec_stall !== 1'b0 || fif.fpu_in_valid !== 1'b1) begin failures++; $display("FAIL raw_issue_after got=%0b/%0b exp=0/1", dec_stall, fif.fpu_in_valid); end
    go();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      op(5 + i, 0, 0, 0, 3'b000); #1;
      checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL full_fill%0d got=%0b exp=0", i, dec_stall); end
      go();
    end
    op(9, 0, 0, 0, 3'b000); #1;
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%0b exp=1", dec_stall); end
    checks++; if (fif.fpu_in_valid !== 1'b0) begin failures++; $display("FAIL full_no_launch got=%0b exp=0", fif.fpu_in_valid); end
    go();
    fif.fpu_out_valid = 1'b1; fif.fpu_result = 32'h1234_5678; #1;
    checks++; if (wb_rd !== 5'd5) begin failures++; $display("FAIL full_wb_head got=%0d exp=5", wb_rd); end
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL full_stall_retire got=%0b exp=1", dec_stall); end
    go();
    fif.fpu_out_valid = 1'b0; #1;
    checks++; if (dec_stall !== 1'b0 || fif.fpu_in_valid !== 1'b1) begin failures++; $display("FAIL full_slot_freed got=%0b/%0b exp=0/1", dec_stall, fif.fpu_in_valid); end
    go();
  endtask

  task automatic test_flush();
    do_reset();
    op(10, 0, 0, 0, 3'b000); go();
    op(11, 0, 0, 0, 3'b000); go();
    dec_fp_valid = 1'b0; fif.fpu_out_valid = 1'b1; fif.fpu_status = 5'b10000; flush_lower = 1'b1; #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_wb_suppressed got=%0b exp=0", wb_valid); end
    go();
    flush_lower = 1'b0; fif.fpu_out_valid = 1'b0; op(12, 10, 0, 0, 3'b001); #1;
    checks++; if (fif.fpu_flush !== 1'b1) begin failures++; $display("FAIL flush_pulse got=%0b exp=1", fif.fpu_flush); end
    checks++; if (fif.fpu_out_ready !== 1'b0) begin failures++; $display("FAIL flush_out_ready got=%0b exp=0", fif.fpu_out_ready); end
    checks++; if (dec_stall !== 1'b1) begin failures++; $display("FAIL flush_stall got=%0b exp=1", dec_stall); end
    checks++; if (sched_state !== FLUSH) begin failures++; $display("FAIL flush_state got=%0d exp=%0d", sched_state, FLUSH); end
    go();
    #1;
    checks++; if (fif.fpu_flush !== 1'b0 || fif.fpu_out_ready !== 1'b1) begin failures++; $display("FAIL flush_end got=%0b/%0b exp=0/1", fif.fpu_flush, fif.fpu_out_ready); end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL flush_queue_empty got=%0b exp=0", sched_busy); end
    checks++; if (dec_stall !== 1'b0) begin failures++; $display("FAIL flush_issue_after got=%0b exp=0", dec_stall); end
    checks++; if (fflags !== 5'b0) begin failures++; $display("FAIL flush_no_accrue got=%b exp=00000", fflags); end
    go();
  endtask

  task automatic test_fflags();
    do_reset();
    op(1, 0, 0, 0, 3'b000); go();
    op(2, 0, 0, 0, 3'b000); go();
    op(3, 0, 0, 0, 3'b000); go();
    dec_fp_valid = 1'b0; fif.fpu_out_valid = 1'b1; fif.fpu_status = 5'b00001; go();
    checks++; if (fflags !== 5'b00001) begin failures++; $display("FAIL ff_nx got=%b exp=00001", fflags); end
    fif.fpu_status = 5'b01000; go();
    checks++; if (fflags !== 5'b01001) begin failures++; $display("FAIL ff_nx_dz got=%b exp=01001", fflags); end
    fif.fpu_status = 5'b00100; csr_fflags_we = 1'b1; csr_fflags_wd = 5'b0; #1;
    checks++; if (wb_rd !== 5'd3) begin failures++; $display("FAIL ff_wb_rd got=%0d exp=3", wb_rd); end
    go();
    checks++; if (fflags !== 5'b00000) begin failures++; $display("FAIL ff_csr_priority got=%b exp=00000", fflags); end
    fif.fpu_out_valid = 1'b0; csr_fflags_we = 1'b0; go();
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op(20 + i, 0, 0, 0, 3'b000); go();
    end
    dec_fp_valid = 1'b0; fif.fpu_out_valid = 1'b1; fif.fpu_status = 5'b00010; go();
    fif.fpu_out_valid = 1'b0; #1;
    rst = 1'b1; #1;
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b exp=0", sched_busy); end
    checks++; if (sched_state !== IDLE) begin failures++; $display("FAIL arst_state got=%0d exp=%0d", sched_state, IDLE); end
    checks++; if (fflags !== 5'b0) begin failures++; $display("FAIL arst_fflags got=%b exp=00000", fflags); end
    checks++; if (fif.fpu_out_ready !== 1'b1 || fif.fpu_flush !== 1'b0) begin failures++; $display("FAIL arst_fpu_ctl got=%0b/%0b exp=1/0", fif.fpu_out_ready, fif.fpu_flush); end
    go();
    rst = 1'b0; op(21, 22, 23, 20, 3'b111); #1;
    checks++; if (dec_stall !== 1'b0 || fif.fpu_in_valid !== 1'b1) begin failures++; $display("FAIL arst_sb_cleared got=%0b/%0b exp=0/1", dec_stall, fif.fpu_in_valid); end
    go();
  endtask

  task automatic test_random();
    bit           haz, launch, iss, ret;
    sched_state_e exp_st;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      dec_fp_valid      = ($urandom_range(0, 3) != 0);
      dec_rd            = RW'($urandom_range(0, 7));
      dec_rs1           = RW'($urandom_range(0, 7));
      dec_rs2           = RW'($urandom_range(0, 7));
      dec_rs3           = RW'($urandom_range(0, 7));
      dec_rs_en         = 3'($urandom_range(0, 7));
      fif.fpu_in_ready  = ($urandom_range(0, 3) != 0);
      fif.fpu_out_valid = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      fif.fpu_result    = $urandom;
      fif.fpu_status    = 5'($urandom_range(0, 31));
      flush_lower       = ($urandom_range(0, 39) == 0);
      csr_fflags_we     = ($urandom_range(0, 19) == 0);
      csr_fflags_wd     = 5'($urandom_range(0, 31));
      #1;
      haz    = (dec_rs_en[0] && in_flight(dec_rs1)) || (dec_rs_en[1] && in_flight(dec_rs2)) ||
               (dec_rs_en[2] && in_flight(dec_rs3)) || in_flight(dec_rd);
      launch = dec_fp_valid && !haz && (exp_q.size() < DEPTH) && !m_flush && !flush_lower;
      iss    = launch && fif.fpu_in_ready;
      ret    = fif.fpu_out_valid && !m_flush && !flush_lower && (exp_q.size() > 0);
      exp_st = m_flush ? FLUSH : ((exp_q.size() != 0) ? BUSY : IDLE);
      checks++; if (dec_stall !== (dec_fp_valid && !iss)) begin failures++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, dec_stall, dec_fp_valid && !iss); end
      checks++; if (fif.fpu_in_valid !== launch) begin failures++; $display("FAIL rnd_in_valid c=%0d got=%0b exp=%0b", c, fif.fpu_in_valid, launch); end
      checks++; if (wb_valid !== ret) begin failures++; $display("FAIL rnd_wb_valid c=%0d got=%0b exp=%0b", c, wb_valid, ret); end
      if (ret) begin
        checks++; if (wb_rd !== exp_q[0] || wb_data !== fif.fpu_result) begin failures++; $display("FAIL rnd_wb c=%0d got=%0d/%h exp=%0d/%h", c, wb_rd, wb_data, exp_q[0], fif.fpu_result); end
      end
      checks++; if (fflags !== m_flags) begin failures++; $display("FAIL rnd_fflags c=%0d got=%b exp=%b", c, fflags, m_flags); end
      checks++; if (sched_busy !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, sched_busy, exp_q.size() != 0); end
      checks++; if (fif.fpu_flush !== m_flush || fif.fpu_out_ready !== !m_flush) begin failures++; $display("FAIL rnd_flush c=%0d got=%0b/%0b exp=%0b/%0b", c, fif.fpu_flush, fif.fpu_out_ready, m_flush, !m_flush); end
      checks++; if (sched_state !== exp_st) begin failures++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, sched_state, exp_st); end
      @(posedge clk);
      if (m_flush) begin
        exp_q.delete();
      end else begin
        if (ret) void'(exp_q.pop_front());
        if (iss) exp_q.push_back(dec_rd);
      end
      if (csr_fflags_we) m_flags = csr_fflags_wd;
      else if (ret)      m_flags = m_flags | fif.fpu_status;
      m_flush = flush_lower;
      #1;
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_full();
    test_flush();
    test_fflags();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
